mxu_host: RTL

MXU_HOST -- requirements
Module: mxu_host

---
 rtl/mxu_pkg.sv | 20 ++
 rtl/mxu_host_if.sv | 20 ++
 rtl/mxu_host_drain.sv | 61 ++++++
 rtl/mxu_host.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mxu_pkg.sv
// Shared definitions for the matrix-unit host: FSM states, default geometry and watchdog limit.
package mxu_pkg;

  localparam int unsigned DEFAULT_SIZE    = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    DRAIN
  } mxu_state_e;

  // Index width for an n-entry array, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mxu_host_if.sv
// Operand byte stream in, result word stream out, as seen by the host (slave) and its feeder (master).
interface mxu_host_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/mxu_host_drain.sv
// Result buffer captured from the engine in one cycle, then streamed out row-major with valid/ready.
module mxu_host_drain
  import mxu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture_i,
  input  logic [N-1:0][31:0] d_in_i,
  input  logic               m_ready_i,
  output logic [31:0]        m_data_o,
  output logic               m_valid_o,
  output logic               m_last_o
);

  localparam int unsigned     CW   = cnt_width(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  logic [N-1:0][31:0] res_q;
  logic [CW-1:0]      idx_q;
  logic [31:0]        data_q;
  logic               valid_q;
  logic               last_q;
  logic [CW-1:0]      idx_nxt_c;

  assign idx_nxt_c = idx_q + CW'(1);

  // Output word is preloaded so m_data is a plain register while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      res_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (capture_i) begin
      res_q   <= d_in_i;
      idx_q   <= '0;
      data_q  <= d_in_i[0];
      valid_q <= 1'b1;
      last_q  <= (LAST == '0);
    end else if (valid_q && m_ready_i) begin
      if (last_q) begin
        idx_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        idx_q   <= idx_nxt_c;
        data_q  <= res_q[idx_nxt_c];
        last_q  <= (idx_nxt_c == LAST);
      end
    end
  end

  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/mxu_host.sv
// Host sequencer for a SIZE x SIZE systolic engine: load A and B, kick the engine, capture and drain results.
// Optional WAIT watchdog enabled by defining MXU_HOST_TIMEOUT_EN.
module mxu_host
  import mxu_pkg::*;
#(
  parameter int unsigned SIZE    = DEFAULT_SIZE,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  mxu_host_if.slave                    bus,
  input  logic [7:0]                   cycles_cfg,
  output logic [SIZE*SIZE-1:0][7:0]    data_a_o,
  output logic [SIZE*SIZE-1:0][7:0]    data_b_o,
  output logic                         start_o,
  output logic [7:0]                   cycles_o,
  input  logic                         done_i,
  input  logic [SIZE*SIZE-1:0][31:0]   d_in,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned   N    = SIZE * SIZE;
  localparam int unsigned   CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mxu_state_e          state_q;
  logic [CW-1:0]       cnt_q;
  logic [N-1:0][7:0]   a_q;
  logic [N-1:0][7:0]   b_q;
  logic [7:0]          cyc_q;
  logic                start_q;
  logic                ready_q;
  logic                busy_q;

  logic accept_c;
  logic capture_c;
  logic drain_end_c;
  logic timeout_c;

  assign accept_c    = bus.s_valid && ready_q;
  assign capture_c   = (state_q == WAIT) && done_i;
  assign drain_end_c = (state_q == DRAIN) && bus.m_valid && bus.m_ready && bus.m_last;

`ifdef MXU_HOST_TIMEOUT_EN
  localparam int unsigned   WW      = cnt_width(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wd_q;
  logic          err_q;

  assign timeout_c = (state_q == WAIT) && !done_i && (wd_q == WD_LAST);

  // Counts consecutive WAIT cycles without done; err is sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == WAIT) && !done_i && !timeout_c) wd_q <= wd_q + WW'(1);
      else                                            wd_q <= '0;
      if (timeout_c) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT;
  assign timeout_c        = 1'b0;
  assign err_o            = 1'b0;
`endif

  // Sequencer; handshake flags are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cyc_q   <= '0;
      start_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: if (accept_c) begin
          a_q[cnt_q] <= bus.s_data;
          if (cnt_q == '0) cyc_q <= cycles_cfg;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= LOAD_B;
            busy_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOAD_B: if (accept_c) begin
          b_q[cnt_q] <= bus.s_data;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= START;
            start_q <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        START: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (capture_c) begin
            state_q <= DRAIN;
          end else if (timeout_c) begin
            state_q <= LOAD_A;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        DRAIN: if (drain_end_c) begin
          state_q <= LOAD_A;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= LOAD_A;
          start_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mxu_host_drain #(.N(N)) u_drain (
    .clk       (clk),
    .reset     (reset),
    .capture_i (capture_c),
    .d_in_i    (d_in),
    .m_ready_i (bus.m_ready),
    .m_data_o  (bus.m_data),
    .m_valid_o (bus.m_valid),
    .m_last_o  (bus.m_last)
  );

  assign bus.s_ready = ready_q;
  assign data_a_o    = a_q;
  assign data_b_o    = b_q;
  assign cycles_o    = cyc_q;
  assign start_o     = start_q;
  assign busy_o      = busy_q;

endmodule
